// File: rtl/usb_link_ctrl.sv
// USB device link controller: attach timing, bus reset and suspend detection,
// resume signalling and transmit-enable gating.
module usb_link_ctrl #(
  parameter int ATTACH_DELAY   = 48000,
  parameter int RESET_CYCLES   = 120,
  parameter int SUSPEND_CYCLES = 144000
) (
  input  logic       clk48,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       usb_d_p_in,
  input  logic       usb_d_n_in,
  input  logic       tx_req,
  output logic       usb_pullup,
  output logic       usb_tx_en,
  output logic       bus_reset,
  output logic       suspend,
  output logic       resume,
  output logic [2:0] state
);

  localparam int AW = $clog2(ATTACH_DELAY) + 1;
  localparam int RW = $clog2(RESET_CYCLES) + 1;
  localparam int SW = $clog2(SUSPEND_CYCLES) + 1;

  localparam logic [AW-1:0] A_MAX = AW'(ATTACH_DELAY - 1);
  localparam logic [RW-1:0] R_MAX = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] S_MAX = SW'(SUSPEND_CYCLES - 1);

  typedef enum logic [2:0] {
    DETACHED    = 3'd0,
    ATTACH_WAIT = 3'd1,
    ACTIVE      = 3'd2,
    BUS_RESET   = 3'd3,
    SUSPENDED   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] att_q, att_d;
  logic [RW-1:0] se0_q, se0_d;
  logic [SW-1:0] j_q, j_d;
  logic          tx_q, tx_d;
  logic          rst_q, rst_d;
  logic          res_q, res_d;
  logic          p_s1, p_s2, n_s1, n_s2;
  logic          line_se0, line_j;

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      p_s1 <= 1'b0;
      p_s2 <= 1'b0;
      n_s1 <= 1'b0;
      n_s2 <= 1'b0;
    end else begin
      p_s1 <= usb_d_p_in;
      p_s2 <= p_s1;
      n_s1 <= usb_d_n_in;
      n_s2 <= n_s1;
    end
  end

  // SE1 decodes as neither, so it clears both idle counters
  assign line_se0 = !p_s2 && !n_s2;
  assign line_j   =  p_s2 && !n_s2;

  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    se0_d   = se0_q;
    j_d     = j_q;
    tx_d    = 1'b0;
    rst_d   = 1'b0;
    res_d   = 1'b0;
    if (!enable) begin
      state_d = DETACHED;
      att_d   = '0;
      se0_d   = '0;
      j_d     = '0;
    end else begin
      unique case (state_q)
        DETACHED: begin
          state_d = ATTACH_WAIT;
          att_d   = '0;
        end
        ATTACH_WAIT: begin
          if (att_q == A_MAX) state_d = ACTIVE;
          else att_d = att_q + 1'b1;
        end
        ACTIVE: begin
          att_d = '0;
          if (tx_q) begin
            // our own EOP/idle must not look like reset or suspend
            se0_d = '0;
            j_d   = '0;
          end else if (line_se0 && se0_q == R_MAX) begin
            state_d = BUS_RESET;
            rst_d   = 1'b1;
            se0_d   = '0;
            j_d     = '0;
          end else if (line_j && j_q == S_MAX) begin
            state_d = SUSPENDED;
            se0_d   = '0;
            j_d     = '0;
          end else begin
            if (!line_se0) se0_d = '0;
            else if (se0_q != R_MAX) se0_d = se0_q + 1'b1;
            if (!line_j) j_d = '0;
            else if (j_q != S_MAX) j_d = j_q + 1'b1;
          end
          tx_d = tx_req && (state_d == ACTIVE);
        end
        BUS_RESET: begin
          se0_d = '0;
          j_d   = '0;
          if (!line_se0) state_d = ACTIVE;
        end
        SUSPENDED: begin
          se0_d = '0;
          j_d   = '0;
          if (!line_j) begin
            state_d = ACTIVE;
            res_d   = 1'b1;
          end
        end
        default: state_d = DETACHED;
      endcase
    end
  end

  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= DETACHED;
      att_q   <= '0;
      se0_q   <= '0;
      j_q     <= '0;
      tx_q    <= 1'b0;
      rst_q   <= 1'b0;
      res_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      se0_q   <= se0_d;
      j_q     <= j_d;
      tx_q    <= tx_d;
      rst_q   <= rst_d;
      res_q   <= res_d;
    end
  end

  assign usb_pullup = (state_q == ACTIVE) ||
                      (state_q == BUS_RESET) ||
                      (state_q == SUSPENDED);
  assign usb_tx_en  = tx_q;
  assign bus_reset  = rst_q;
  assign suspend    = (state_q == SUSPENDED);
  assign resume     = res_q;
  assign state      = state_q;

endmodule

// File: tb/tb_usb_link_ctrl.sv
// Directed bench for usb_link_ctrl with short timing parameters.
module tb_usb_link_ctrl;

  logic       clk48 = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       dp, dn;
  logic       tx_req;
  logic       usb_pullup, usb_tx_en, bus_reset, suspend, resume;
  logic [2:0] state;

  int total = 0;
  int bad = 0;

  always #5 clk48 = ~clk48;

  usb_link_ctrl #(
    .ATTACH_DELAY(16),
    .RESET_CYCLES(8),
    .SUSPEND_CYCLES(32)
  ) dut (
    .clk48(clk48),
    .reset_n(reset_n),
    .enable(enable),
    .usb_d_p_in(dp),
    .usb_d_n_in(dn),
    .tx_req(tx_req),
    .usb_pullup(usb_pullup),
    .usb_tx_en(usb_tx_en),
    .bus_reset(bus_reset),
    .suspend(suspend),
    .resume(resume),
    .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic line(input logic p, input logic n);
    dp = p;
    dn = n;
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    tx_req  = 1'b0;
    line(1'b0, 1'b1);
    #2;
    check("rst_state", state, 0);
    check("rst_pullup", usb_pullup, 0);
    check("rst_txen", usb_tx_en, 0);
    check("rst_busrst", bus_reset, 0);
    check("rst_susp", suspend, 0);
    check("rst_resume", resume, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("idle_detached", state, 0);

    // attach: 16 cycles in ATTACH_WAIT
    enable = 1'b1;
    tick();
    check("attach_enter", state, 1);
    check("attach_pullup", usb_pullup, 0);
    for (int i = 0; i < 15; i++) begin
      tick();
      check("attach_wait", state, 1);
    end
    tick();
    check("attach_active", state, 2);
    check("active_pullup", usb_pullup, 1);

    // 7 SE0 samples: below threshold
    line(1'b0, 1'b0);
    repeat (7) tick();
    line(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("se0_short_nobr", bus_reset, 0);
      check("se0_short_state", state, 2);
    end

    // held SE0: bus reset 10 cycles after the pins change
    line(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      check("se0_pre_state", state, 2);
      check("se0_pre_br", bus_reset, 0);
    end
    tick();
    check("br_state", state, 3);
    check("br_pulse", bus_reset, 1);
    check("br_pullup", usb_pullup, 1);
    tick();
    check("br_pulse_end", bus_reset, 0);
    check("br_hold", state, 3);
    line(1'b1, 1'b0);
    tick();
    tick();
    check("br_sync_delay", state, 3);
    tick();
    check("br_exit", state, 2);
    check("br_exit_nopulse", bus_reset, 0);
    line(1'b0, 1'b1);
    repeat (4) tick();

    // suspend after 32 J samples
    line(1'b1, 1'b0);
    for (int i = 0; i < 33; i++) tick();
    check("susp_pre_state", state, 2);
    check("susp_pre_flag", suspend, 0);
    tick();
    check("susp_state", state, 4);
    check("susp_flag", suspend, 1);
    check("susp_pullup", usb_pullup, 1);
    line(1'b0, 1'b1);
    tick();
    tick();
    check("susp_hold", state, 4);
    check("susp_noresume", resume, 0);
    tick();
    check("wake_state", state, 2);
    check("wake_resume", resume, 1);
    check("wake_susp", suspend, 0);
    check("wake_nobr", bus_reset, 0);
    tick();
    check("resume_end", resume, 0);

    // transmit: own SE0/J must not trigger reset or suspend
    tx_req = 1'b1;
    tick();
    check("tx_on", usb_tx_en, 1);
    line(1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("tx_se0_nobr", bus_reset, 0);
      check("tx_se0_en", usb_tx_en, 1);
    end
    line(1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("tx_j_nosusp", suspend, 0);
    end
    check("tx_state", state, 2);
    line(1'b0, 1'b1);
    repeat (3) tick();
    tx_req = 1'b0;
    check("tx_still_on", usb_tx_en, 1);
    tick();
    check("tx_off", usb_tx_en, 0);
    tick();
    check("tx_after_state", state, 2);

    // reset mid-transmit, then re-attach with enable still high
    tx_req = 1'b1;
    tick();
    check("tx2_on", usb_tx_en, 1);
    reset_n = 1'b0;
    #1;
    check("arst_txen", usb_tx_en, 0);
    check("arst_state", state, 0);
    check("arst_pullup", usb_pullup, 0);
    #2;
    reset_n = 1'b1;
    tx_req  = 1'b0;
    tick();
    check("reattach_enter", state, 1);
    repeat (15) tick();
    check("reattach_wait", state, 1);
    tick();
    check("reattach_active", state, 2);

    // detach
    enable = 1'b0;
    tick();
    check("detach_state", state, 0);
    check("detach_pullup", usb_pullup, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_link_ctrl.md
USB_LINK_CTRL -- requirements
Module: usb_link_ctrl

Interface
REQ-001 SHALL have parameter ATTACH_DELAY, default 48000, clk48 cycles from enable to pullup (1 ms).
REQ-002 SHALL have parameter RESET_CYCLES, default 120, consecutive SE0 cycles that detect a bus reset (2.5 us).
REQ-003 SHALL have parameter SUSPEND_CYCLES, default 144000, consecutive idle-J cycles that detect suspend (3 ms).
REQ-004 SHALL have port clk48  input  1  48 MHz clock; single clock domain.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  attach request; low forces detach.
REQ-007 SHALL have port usb_d_p_in  input  1  raw D+ line sample (asynchronous).
REQ-008 SHALL have port usb_d_n_in  input  1  raw D- line sample (asynchronous).
REQ-009 SHALL have port tx_req  input  1  core requests to drive the bus.
REQ-010 SHALL have port usb_pullup  output  1  D+ 1.5k pullup enable.
REQ-011 SHALL have port usb_tx_en  output  1  bus driver output enable.
REQ-012 SHALL have port bus_reset  output  1  one-cycle pulse on bus-reset detect.
REQ-013 SHALL have port suspend  output  1  level, high while suspended.
REQ-014 SHALL have port resume  output  1  one-cycle pulse on wake from suspend.
REQ-015 SHALL have port state  output  3  current state encoding (below).

Function
REQ-016 SHALL pass usb_d_p_in/usb_d_n_in through a 2-flop synchronizer; all detection uses the synchronized pair (2-cycle latency).
REQ-017 SHALL decode synchronized line: SE0 = D+0/D-0; J = D+1/D-0; K = D+0/D-1; SE1 treated as neither (clears both counters).
REQ-018 SHALL implement states DETACHED=0, ATTACH_WAIT=1, ACTIVE=2, BUS_RESET=3, SUSPENDED=4.
REQ-019 DETACHED: pullup 0; enable=1 -> ATTACH_WAIT with attach counter cleared.
REQ-020 ATTACH_WAIT: pullup 0; counter increments each cycle; at ATTACH_DELAY-1 -> ACTIVE next cycle.
REQ-021 ACTIVE: pullup 1; SE0 counter increments per SE0 sample, cleared otherwise; reaching RESET_CYCLES-1 with SE0 -> BUS_RESET.
REQ-022 ACTIVE: J counter increments per J sample, cleared otherwise; reaching SUSPEND_CYCLES-1 with J -> SUSPENDED.
REQ-023 BUS_RESET: pullup 1; bus_reset pulses high on the entry cycle only; first non-SE0 sample -> ACTIVE, counters cleared.
REQ-024 SUSPENDED: suspend=1; any non-J sample -> ACTIVE, resume pulses high on the ACTIVE entry cycle, suspend=0 same cycle.
REQ-025 enable=0 in any state SHALL force DETACHED next cycle: pullup 0, usb_tx_en 0, suspend 0, all counters cleared; highest priority.
REQ-026 usb_tx_en SHALL be registered: tx_req AND state==ACTIVE (and no transition pending this cycle), 1-cycle latency; deasserts 1 cycle after tx_req drops.
REQ-027 While usb_tx_en=1, SE0 and J counters SHALL be held at 0 (own EOP/idle never self-detects reset or suspend).
REQ-028 Transition in same cycle as tx_req: transition wins, usb_tx_en stays 0.
REQ-029 Counters SHALL be sized clog2(param)+1 bits and SHALL never wrap (saturate).
REQ-030 bus_reset and resume SHALL never be high simultaneously; each is exactly one cycle.

Reset
REQ-031 reset_n low SHALL asynchronously force: state DETACHED, usb_pullup 0, usb_tx_en 0, bus_reset 0, suspend 0, resume 0, counters and synchronizer flops 0.
REQ-032 Release of reset_n SHALL take effect on the next clk48 edge; reset mid-transmit drops usb_tx_en immediately.

Verification (ATTACH_DELAY=16, RESET_CYCLES=8, SUSPEND_CYCLES=32)
REQ-033 enable 0->1 -> state 1 for 16 cycles, then state 2, usb_pullup=1; enable->0 -> state 0, pullup 0 next cycle.
REQ-034 ACTIVE, SE0 held 7 cycles then J -> no bus_reset; SE0 held 8+ cycles -> state 3, single bus_reset pulse 10 cycles after pin SE0 (2 sync + 8); J -> state 2.
REQ-035 ACTIVE, J held 32 cycles -> state 4, suspend=1; then K -> state 2, resume 1-cycle pulse, suspend 0.
REQ-036 ACTIVE, tx_req=1 with SE0/J on line for 40 cycles -> usb_tx_en=1 from cycle after tx_req, no bus_reset/suspend; tx_req=0 -> usb_tx_en 0 one cycle later.
REQ-037 reset_n pulsed low mid-transmit in ACTIVE -> all outputs 0 asynchronously, state 0; enable still high -> re-attach after 16 cycles.
